// File: rtl/riscv_pkg.sv
// Shared definitions for the integer datapath: machine width, add/sub op
// select encoding and the result flags bundle.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic carry;
    logic ovf;
    logic zero;
  } addsub_flags_t;

endpackage

// File: rtl/addsub_slice.sv
// Combinational W-bit ripple slice with carry-in and carry-out; one per
// pipeline stage of pipelined_addsub.
module addsub_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined signed add/subtract: the carry chain is cut into STAGES slices,
// one per cycle. Optional saturation on overflow with PIPELINED_ADDSUB_SAT_EN.
module pipelined_addsub
  import riscv_pkg::*;
#(
  parameter int WIDTH  = XLEN,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int SLICE = WIDTH / STAGES;
  localparam int NP    = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int LAST  = STAGES - 1;

  // Stage inputs (operands travel whole; the partial sum fills from the bottom)
  logic [STAGES-1:0][WIDTH-1:0] st_a_s, st_b_s, st_sum_s, res_s;
  logic [STAGES-1:0][SLICE-1:0] slice_s;
  logic [STAGES-1:0]            st_c_s, st_v_s, cout_s;

  logic [NP-1:0][WIDTH-1:0] pa_r, pb_r, psum_r;
  logic [NP-1:0]            pc_r, pv_r;

  logic                adv_s;
  logic [WIDTH-1:0]    raw_s, final_s;
  addsub_flags_t       flags_s, flags_r;
  logic                out_valid_r;
  logic [WIDTH-1:0]    out_sum_r;

  assign adv_s    = !out_valid_r | out_ready;
  assign in_ready = adv_s;

  // Route each stage's inputs: ports for stage 0, skew registers otherwise
  always_comb begin
    st_a_s      = '0;
    st_b_s      = '0;
    st_sum_s    = '0;
    st_c_s      = '0;
    st_v_s      = '0;
    st_a_s[0]   = in_a;
    st_b_s[0]   = (in_sub == OP_SUB) ? ~in_b : in_b;
    st_c_s[0]   = in_sub;
    st_v_s[0]   = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      st_a_s[k]   = pa_r[k-1];
      st_b_s[k]   = pb_r[k-1];
      st_sum_s[k] = psum_r[k-1];
      st_c_s[k]   = pc_r[k-1];
      st_v_s[k]   = pv_r[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    addsub_slice #(.W(SLICE)) u_slice (
      .a   (st_a_s[k][k*SLICE +: SLICE]),
      .b   (st_b_s[k][k*SLICE +: SLICE]),
      .cin (st_c_s[k]),
      .sum (slice_s[k]),
      .cout(cout_s[k])
    );
  end

  // Merge each new slice into its partial sum; upper bits are still zero
  always_comb begin
    res_s = '0;
    for (int k = 0; k < STAGES; k++) begin
      res_s[k] = st_sum_s[k] | (WIDTH'(slice_s[k]) << (k * SLICE));
    end
  end

  // Final-stage flags and optional saturation
  always_comb begin
    raw_s         = res_s[LAST];
    flags_s.carry = cout_s[LAST];
    flags_s.ovf   = (st_a_s[LAST][WIDTH-1] == st_b_s[LAST][WIDTH-1]) &
                    (raw_s[WIDTH-1] != st_a_s[LAST][WIDTH-1]);
`ifdef PIPELINED_ADDSUB_SAT_EN
    if (flags_s.ovf) begin
      if (st_a_s[LAST][WIDTH-1]) begin
        final_s = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        final_s = {1'b0, {(WIDTH-1){1'b1}}};
      end
    end else begin
      final_s = raw_s;
    end
`else
    final_s = raw_s;
`endif
    flags_s.zero = (final_s == {WIDTH{1'b0}});
  end

  // Intermediate skew registers; everything holds while the output stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pa_r   <= '0;
      pb_r   <= '0;
      psum_r <= '0;
      pc_r   <= '0;
      pv_r   <= '0;
    end else if (adv_s) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        pa_r[k]   <= st_a_s[k];
        pb_r[k]   <= st_b_s[k];
        psum_r[k] <= res_s[k];
        pc_r[k]   <= cout_s[k];
        pv_r[k]   <= st_v_s[k];
      end
    end
  end

  // Output register; data only moves for real ops so bubbles leave it alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_sum_r   <= '0;
      flags_r     <= '0;
    end else if (adv_s) begin
      out_valid_r <= st_v_s[LAST];
      if (st_v_s[LAST]) begin
        out_sum_r <= final_s;
        flags_r   <= flags_s;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_sum   = out_sum_r;
  assign out_carry = flags_r.carry;
  assign out_ovf   = flags_r.ovf;
  assign out_zero  = flags_r.zero;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub at STAGES=4 (main), 1 and 8.
module tb_pipelined_addsub;

`ifdef PIPELINED_ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a_t = 32'h0, b_t = 32'h0;
  logic        sub_t = 1'b0;
  logic [2:0]  iv = 3'b000, ordy = 3'b111;
  logic [2:0]  irdy, ov, oc, oo, oz;
  logic [31:0] os [3];

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
    .in_a(a_t), .in_b(b_t), .in_sub(sub_t), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_sum(os[0]), .out_carry(oc[0]), .out_ovf(oo[0]), .out_zero(oz[0]));

  pipelined_addsub #(.WIDTH(32), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
    .in_a(a_t), .in_b(b_t), .in_sub(sub_t), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_sum(os[1]), .out_carry(oc[1]), .out_ovf(oo[1]), .out_zero(oz[1]));

  pipelined_addsub #(.WIDTH(32), .STAGES(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]),
    .in_a(a_t), .in_b(b_t), .in_sub(sub_t), .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_sum(os[2]), .out_carry(oc[2]), .out_ovf(oo[2]), .out_zero(oz[2]));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] s;
    logic        c;
    logic        o;
    logic        z;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // Issue one op on DUT d and count edges from accept to out_valid
  task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b,
                        input logic s, output int lat);
    @(negedge clk);
    a_t = a; b_t = b; sub_t = s; iv[d] = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    iv[d] = 1'b0;
    while (!ov[d] && lat < 30) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int got [$];
    int sent, cyc, ovcnt;
    logic [31:0] held;
    string nm;

    vt[0] = '{32'd5,         32'd7,         1'b0, 32'd12,        1'b0, 1'b0, 1'b0};
    vt[1] = '{32'h0000_FFFF, 32'd1,         1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
    vt[2] = '{32'hFFFF_FFFF, 32'd1,         1'b0, 32'h0,         1'b1, 1'b0, 1'b1};
    vt[3] = '{32'd0,         32'd1,         1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vt[4] = '{32'd9,         32'd9,         1'b1, 32'h0,         1'b1, 1'b0, 1'b1};
    vt[5] = '{32'h7FFF_FFFF, 32'd1,         1'b0,
              SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vt[6] = '{32'h8000_0000, 32'd1,         1'b1,
              SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vt[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0,
              SAT ? 32'h8000_0000 : 32'h0, 1'b1, 1'b1, SAT ? 1'b0 : 1'b1};
    vt[8] = '{32'h1234_5678, 32'h0000_0678, 1'b1, 32'h1234_5000, 1'b1, 1'b0, 1'b0};
    vt[9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {29'd0, ov}, 32'd0);
    chk("rst_out_sum", os[0], 32'd0);
    chk("rst_flags", {29'd0, oc[0], oo[0], oz[0]}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {29'd0, irdy}, 32'd7);

    // Vector table on the 4-stage unit
    for (int i = 0; i < 10; i++) begin
      run_op(0, vt[i].a, vt[i].b, vt[i].sub, lat);
      nm = $sformatf("v%0d", i);
      chk({nm, "_lat"}, lat, 32'd4);
      chk({nm, "_sum"}, os[0], vt[i].s);
      chk({nm, "_carry"}, {31'd0, oc[0]}, {31'd0, vt[i].c});
      chk({nm, "_ovf"}, {31'd0, oo[0]}, {31'd0, vt[i].o});
      chk({nm, "_zero"}, {31'd0, oz[0]}, {31'd0, vt[i].z});
    end
    @(negedge clk);

    // Backpressure: 8 back-to-back adds, out_ready low in cycles 6..10
    sent = 0;
    held = 32'h0;
    for (cyc = 0; cyc < 60 && got.size() < 8; cyc++) begin
      ordy[0] = !(cyc >= 6 && cyc <= 10);
      iv[0] = (sent < 8);
      a_t = sent; b_t = 32'd100; sub_t = 1'b0;
      #1;
      if (cyc == 6) held = os[0];
      if (cyc >= 6 && cyc <= 10) begin
        chk($sformatf("bp_in_ready_c%0d", cyc), {31'd0, irdy[0]}, 32'd0);
        chk($sformatf("bp_hold_c%0d", cyc), os[0], held);
      end
      if (ov[0] && ordy[0]) got.push_back(os[0]);
      if (iv[0] && irdy[0]) sent++;
      @(negedge clk);
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    chk("bp_count", got.size(), 32'd8);
    for (int i = 0; i < got.size(); i++)
      chk($sformatf("bp_res%0d", i), got[i], i + 100);
    repeat (3) @(negedge clk);
    chk("bp_drained", {31'd0, ov[0]}, 32'd0);

    // Reset with ops in flight: one at the output, two behind it
    for (int i = 1; i <= 4; i++) begin
      iv[0] = (i <= 3);
      a_t = i; b_t = 32'd0; sub_t = 1'b0;
      @(negedge clk);
    end
    iv[0] = 1'b0;
    chk("mf_pre_valid", {31'd0, ov[0]}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mf_rst_valid", {31'd0, ov[0]}, 32'd0);
    chk("mf_rst_sum", os[0], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ovcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ov[0]) ovcnt++;
    end
    chk("mf_no_stale", ovcnt, 32'd0);
    run_op(0, 32'd20, 32'd22, 1'b0, lat);
    chk("mf_fresh_lat", lat, 32'd4);
    chk("mf_fresh_sum", os[0], 32'd42);

    // Other depths
    run_op(1, 32'd5, 32'd7, 1'b0, lat);
    chk("s1_lat", lat, 32'd1);
    chk("s1_sum", os[1], 32'd12);
    run_op(2, 32'd5, 32'd7, 1'b0, lat);
    chk("s8_lat", lat, 32'd8);
    chk("s8_sum", os[2], 32'd12);
    run_op(2, 32'h7FFF_FFFF, 32'd1, 1'b0, lat);
    chk("s8_ovf", {31'd0, oo[2]}, 32'd1);
    chk("s8_ovf_sum", os[2], SAT ? 32'h7FFF_FFFF : 32'h8000_0000);

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
